// File: rtl/lc3b_types.sv
// Shared types and helpers for the LC-3b data cache: line type, controller states,
// and word select / byte merge functions used by the cache datapath.
package lc3b_types;

    typedef logic [127:0] lc3b_line;
    typedef logic [15:0]  lc3b_word;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2
    } lc3b_dcache_state_t;

    localparam int DCACHE_OFFSET_BITS = 4;

    function automatic lc3b_word line_word(input lc3b_line line, input logic [2:0] word);
        return line[{word, 4'h0} +: 16];
    endfunction

    // mask[0] enables the low (even) byte of the word, mask[1] the high byte
    function automatic lc3b_line line_merge(input lc3b_line line, input logic [2:0] word,
                                            input lc3b_word data, input logic [1:0] mask);
        lc3b_line merged;
        merged = line;
        if (mask[0]) merged[{word, 4'h0} +: 8] = data[7:0];
        if (mask[1]) merged[{word, 4'h8} +: 8] = data[15:8];
        return merged;
    endfunction

endpackage

// File: rtl/dcache_datapath.sv
// Direct-mapped cache storage: data/tag/valid arrays, tag compare, word select,
// byte merge for stores and the registered merged line sent to memory.
module dcache_datapath
    import lc3b_types::*;
#(
    parameter int NUM_SETS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] address,
    input  logic [15:0] wdata,
    input  logic [1:0]  wmask,
    input  logic        write_en,
    input  logic        fill_en,
    input  logic [15:0] fill_address,
    input  lc3b_line    fill_data,
    output logic        hit,
    output logic [15:0] rdata,
    output lc3b_line    wline
);

    localparam int INDEX_BITS = $clog2(NUM_SETS);
    localparam int TAG_BITS   = 16 - DCACHE_OFFSET_BITS - INDEX_BITS;

    lc3b_line                data_r [NUM_SETS];
    logic [TAG_BITS-1:0]     tag_r  [NUM_SETS];
    logic [NUM_SETS-1:0]     valid_r;
    lc3b_line                wline_r;

    logic [INDEX_BITS-1:0]   index_s;
    logic [INDEX_BITS-1:0]   fill_index_s;
    logic [TAG_BITS-1:0]     tag_s;
    logic [TAG_BITS-1:0]     fill_tag_s;
    logic [2:0]              word_s;
    lc3b_line                line_s;
    lc3b_line                merged_s;
    logic                    unused_s;

    assign index_s      = address[DCACHE_OFFSET_BITS +: INDEX_BITS];
    assign tag_s        = address[15 -: TAG_BITS];
    assign word_s       = address[3:1];
    assign fill_index_s = fill_address[DCACHE_OFFSET_BITS +: INDEX_BITS];
    assign fill_tag_s   = fill_address[15 -: TAG_BITS];
    // byte lanes come from wmask and fills are line aligned, so these bits carry nothing
    assign unused_s     = ^{address[0], fill_address[3:0]};

    assign line_s   = data_r[index_s];
    assign merged_s = line_merge(line_s, word_s, wdata, wmask);
    assign hit      = valid_r[index_s] && (tag_r[index_s] == tag_s);
    assign rdata    = line_word(line_s, word_s);
    assign wline    = wline_r;

    // Valid bits: cleared by reset, set when a fetched line is installed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= '0;
        end else if (fill_en) begin
            valid_r[fill_index_s] <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Data and tag storage: line install on fill, byte merge on store hit
    always_ff @(posedge clk) begin
        if (fill_en) begin
            data_r[fill_index_s] <= fill_data;
            tag_r[fill_index_s]  <= fill_tag_s;
        end else if (write_en) begin
            data_r[index_s] <= merged_s;
        end
    end

    // Merged line captured for the write-through transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wline_r <= '0;
        end else if (write_en) begin
            wline_r <= merged_s;
        end else begin
            wline_r <= wline_r;
        end
    end

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped write-through, write-allocate data cache controller for the MEM stage.
// Optional DCACHE_PERF_EN adds saturating hit_count/miss_count outputs.
module dcache_responder
    import lc3b_types::*;
#(
    parameter int NUM_SETS   = 8,
    parameter int LINE_BYTES = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [15:0]   mem_address,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic [15:0]   mem_wdata,
    input  logic [1:0]    mem_wmask,
    output logic [15:0]   mem_rdata,
    output logic          mem_resp,
    output logic [15:0]   pmem_address,
    output logic          pmem_read,
    output logic          pmem_write,
    output logic [127:0]  pmem_wdata,
    input  logic [127:0]  pmem_rdata,
    input  logic          pmem_resp
`ifdef DCACHE_PERF_EN
    ,
    output logic [15:0]   hit_count,
    output logic [15:0]   miss_count
`endif
);

    localparam int OFFSET_BITS = $clog2(LINE_BYTES);

    lc3b_dcache_state_t state_r, next_s;
    logic        pmem_read_r;
    logic        pmem_write_r;
    logic [15:0] line_addr_r;

    logic        hit_s;
    logic [15:0] rdata_s;
    logic        mem_resp_s;
    logic        rd_resp_s;
    logic        fill_en_s;
    logic        write_en_s;
    logic        load_addr_s;

    dcache_datapath #(.NUM_SETS(NUM_SETS)) u_datapath (
        .clk          (clk),
        .rst_n        (rst_n),
        .address      (mem_address),
        .wdata        (mem_wdata),
        .wmask        (mem_wmask),
        .write_en     (write_en_s),
        .fill_en      (fill_en_s),
        .fill_address (line_addr_r),
        .fill_data    (pmem_rdata),
        .hit          (hit_s),
        .rdata        (rdata_s),
        .wline        (pmem_wdata)
    );

    // Next-state and control decode; a write that completes in WRITE is never re-issued from it
    always_comb begin
        next_s      = state_r;
        mem_resp_s  = 1'b0;
        rd_resp_s   = 1'b0;
        fill_en_s   = 1'b0;
        write_en_s  = 1'b0;
        load_addr_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (mem_write) begin
                    load_addr_s = 1'b1;
                    if (hit_s) begin
                        write_en_s = 1'b1;
                        next_s     = WRITE;
                    end else begin
                        next_s     = FETCH;
                    end
                end else if (mem_read) begin
                    if (hit_s) begin
                        mem_resp_s = 1'b1;
                        rd_resp_s  = 1'b1;
                    end else begin
                        load_addr_s = 1'b1;
                        next_s      = FETCH;
                    end
                end else begin
                    next_s = IDLE;
                end
            end
            FETCH: begin
                if (pmem_resp) begin
                    fill_en_s = 1'b1;
                    next_s    = IDLE;
                end else begin
                    next_s    = FETCH;
                end
            end
            WRITE: begin
                if (pmem_resp) begin
                    mem_resp_s = mem_write;
                    next_s     = IDLE;
                end else begin
                    next_s     = WRITE;
                end
            end
            default: begin
                next_s = IDLE;
            end
        endcase
    end

    // State, memory strobes and the latched line address of the outstanding transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            pmem_read_r  <= 1'b0;
            pmem_write_r <= 1'b0;
            line_addr_r  <= 16'h0000;
        end else begin
            state_r      <= next_s;
            pmem_read_r  <= (next_s == FETCH);
            pmem_write_r <= (next_s == WRITE);
            if (load_addr_s) begin
                line_addr_r <= {mem_address[15:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            end else begin
                line_addr_r <= line_addr_r;
            end
        end
    end

    // Read data is forced to zero outside a read-hit response
    always_comb begin
        mem_resp  = mem_resp_s;
        mem_rdata = rd_resp_s ? rdata_s : 16'h0000;
    end

    assign pmem_read    = pmem_read_r;
    assign pmem_write   = pmem_write_r;
    assign pmem_address = line_addr_r;

`ifdef DCACHE_PERF_EN
    logic [15:0] hit_count_r;
    logic [15:0] miss_count_r;
    logic        after_fetch_r;
    logic        hit_event_s;

    // The access replayed right after a fill was already counted as a miss
    assign hit_event_s = (state_r == IDLE) && hit_s && (mem_read || mem_write) && !after_fetch_r;

    // Saturating performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count_r   <= 16'h0000;
            miss_count_r  <= 16'h0000;
            after_fetch_r <= 1'b0;
        end else begin
            after_fetch_r <= fill_en_s;
            if (hit_event_s && (hit_count_r != 16'hFFFF)) begin
                hit_count_r <= hit_count_r + 16'h0001;
            end else begin
                hit_count_r <= hit_count_r;
            end
            if ((state_r == IDLE) && (next_s == FETCH) && (miss_count_r != 16'hFFFF)) begin
                miss_count_r <= miss_count_r + 16'h0001;
            end else begin
                miss_count_r <= miss_count_r;
            end
        end
    end

    assign hit_count  = hit_count_r;
    assign miss_count = miss_count_r;
`endif

endmodule
